// File: rtl/mips_defs.sv
// Shared fetch-stage constants and the IF/ID payload record.
// Later pipeline-stage registers reuse if_id_t and fetch_legal().
package mips_defs;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0004;
    localparam logic [31:0] IMEM_SIZE = 32'h0000_0800;
    localparam logic [31:0] PC_INCR   = 32'h0000_0004;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // IMEM maps word 0 at byte address 4, so the legal window is [4, size].
    function automatic logic fetch_legal(input logic [31:0] pc, input logic [31:0] size);
        return (pc[1:0] == 2'b00) && (pc >= PC_INCR) && (pc <= size);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold keeps contents, bubble loads an invalid NOP.
// Hold wins over bubble; the caller decides what a redirect overrides.
module if_id_reg
    import mips_defs::*;
#(
    parameter logic [31:0] NOP = NOP_WORD
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '{instr: NOP, pc: '0, pc_plus4: '0, valid: 1'b0};
        end else if (!hold) begin
            if (bubble) q <= '{instr: NOP, pc: d.pc, pc_plus4: d.pc_plus4, valid: 1'b0};
            else        q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives IMEM, fills IF/ID, and tracks faults and
// delivered-instruction count. Redirect beats stall beats flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
    parameter logic [31:0] IMEM_SIZE = mips_defs::IMEM_SIZE,
    parameter logic [31:0] NOP_WORD  = mips_defs::NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);
    import mips_defs::*;

    logic [31:0] pc;
    logic        legal;
    logic        hold;
    logic        bubble;
    logic        load_valid;
    logic        fault_now;
    if_id_t      d;
    if_id_t      q;

    assign imem_address = pc;
    assign legal        = fetch_legal(pc, IMEM_SIZE);

    always_comb begin
        // A redirect discards the wrong-path word even when stalled.
        hold       = stall & ~redirect_valid;
        bubble     = redirect_valid | flush | ~legal;
        load_valid = ~hold & ~bubble;
        fault_now  = ~hold & ~redirect_valid & ~flush & ~legal;
        d          = '{instr: imem_instruction, pc: pc, pc_plus4: pc + PC_INCR, valid: 1'b1};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_target;
        else if (!stall)         pc <= pc + PC_INCR;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (fault_now)  fetch_fault <= 1'b1;
            if (load_valid) fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg #(.NOP(NOP_WORD)) u_if_id (
        .clock  (clock),
        .reset  (reset),
        .hold   (hold),
        .bubble (bubble),
        .d      (d),
        .q      (q)
    );

    assign if_id_instruction = q.instr;
    assign if_id_pc          = q.pc;
    assign if_id_pc_plus4    = q.pc_plus4;
    assign if_id_valid       = q.valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, boundary sequences,
// then randomized control traffic against a behavioural fetch model.
module tb_instr_fetch_unit;

    localparam logic [31:0] SIZE = 32'h800;
    localparam int          NW   = 512;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [NW];

    instr_fetch_unit dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .if_id_instruction(if_id_instruction),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .fetch_fault      (fetch_fault),
        .fetch_count      (fetch_count)
    );

    always #5 clock = ~clock;

    // Combinational IMEM; outside the ROM it returns recognisable junk.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - 32'd4) >> 2;
        if (idx < NW) return rom[idx];
        return 32'hBAD0_0000 | {16'h0, idx[15:0]};
    endfunction

    always_comb imem_instruction = rom_word(imem_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] tg);
        stall = st; flush = fl; redirect_valid = rv; redirect_target = tg;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".addr"},  imem_address, 32'h4);
        chk({tag, ".instr"}, if_id_instruction, 32'h0);
        chk({tag, ".pc"},    if_id_pc, 32'h0);
        chk({tag, ".pc4"},   if_id_pc_plus4, 32'h0);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'h0);
        chk({tag, ".fault"}, {31'b0, fetch_fault}, 32'h0);
        chk({tag, ".count"}, fetch_count, 32'h0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0);
        #2 reset = 1'b0;
        #1 chk_reset("async_rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid, m_fault;

    task automatic model_reset();
        m_pc = 32'h4; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
        m_valid = 0; m_fault = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic rv, input logic [31:0] tg);
        bit ok;
        ok = (m_pc % 4 == 0) && (m_pc >= 4) && (m_pc <= SIZE);
        if (rv) begin
            m_valid = 0; m_instr = 0; m_pc = tg;
        end else if (st) begin
            // everything holds
        end else if (fl) begin
            m_valid = 0; m_instr = 0; m_pc = m_pc + 4;
        end else begin
            if (ok) begin
                m_valid = 1; m_instr = rom_word(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 4;
                m_cnt = m_cnt + 1;
            end else begin
                m_valid = 0; m_instr = 0; m_fault = 1;
            end
            m_pc = m_pc + 4;
        end
    endtask

    task automatic cmp_model();
        chk("rnd.addr",  imem_address, m_pc);
        chk("rnd.valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("rnd.instr", if_id_instruction, m_instr);
        chk("rnd.fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        chk("rnd.count", fetch_count, m_cnt);
        if (m_valid) begin
            chk("rnd.pc",  if_id_pc, m_ipc);
            chk("rnd.pc4", if_id_pc_plus4, m_ipc4);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st, fl, rv;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc, einstr, eaddr;
        logic        ef;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vec [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NW; i++) rom[i] = $urandom;
        rom[0] = 32'h2008_0001; rom[1] = 32'h2009_0002;
        rom[2] = 32'h0109_5020; rom[3] = 32'h0000_0000;
        rom[15] = 32'h8C0A_0040;

        vec[0]  = '{0,0,0,0,           1, 32'h04, 32'h2008_0001, 32'h08, 0, 1};
        vec[1]  = '{0,0,0,0,           1, 32'h08, 32'h2009_0002, 32'h0C, 0, 2};
        vec[2]  = '{1,0,0,0,           1, 32'h08, 32'h2009_0002, 32'h0C, 0, 2};
        vec[3]  = '{1,0,0,0,           1, 32'h08, 32'h2009_0002, 32'h0C, 0, 2};
        vec[4]  = '{1,0,0,0,           1, 32'h08, 32'h2009_0002, 32'h0C, 0, 2};
        vec[5]  = '{0,0,0,0,           1, 32'h0C, 32'h0109_5020, 32'h10, 0, 3};
        vec[6]  = '{0,0,0,0,           1, 32'h10, 32'h0000_0000, 32'h14, 0, 4};
        vec[7]  = '{1,0,1,32'h40,      0, 0,      0,             32'h40, 0, 4};
        vec[8]  = '{0,0,0,0,           1, 32'h40, 32'h8C0A_0040, 32'h44, 0, 5};
        vec[9]  = '{0,0,1,32'h08,      0, 0,      0,             32'h08, 0, 5};
        vec[10] = '{0,1,0,0,           0, 0,      0,             32'h0C, 0, 5};
        vec[11] = '{0,0,0,0,           1, 32'h0C, 32'h0109_5020, 32'h10, 0, 6};
        vec[12] = '{0,0,1,32'h42,      0, 0,      0,             32'h42, 0, 6};
        vec[13] = '{0,0,0,0,           0, 0,      0,             32'h46, 1, 6};
        vec[14] = '{0,0,1,32'h10,      0, 0,      0,             32'h10, 1, 6};
        vec[15] = '{0,0,0,0,           1, 32'h10, 32'h0000_0000, 32'h14, 1, 7};

        #12;
        chk_reset("reset");
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vec[i].st, vec[i].fl, vec[i].rv, vec[i].tgt);
            chk($sformatf("vec%0d.valid", i), {31'b0, if_id_valid}, {31'b0, vec[i].ev});
            chk($sformatf("vec%0d.instr", i), if_id_instruction, vec[i].einstr);
            chk($sformatf("vec%0d.addr", i),  imem_address, vec[i].eaddr);
            chk($sformatf("vec%0d.fault", i), {31'b0, fetch_fault}, {31'b0, vec[i].ef});
            chk($sformatf("vec%0d.count", i), fetch_count, vec[i].ecnt);
            if (vec[i].ev) begin
                chk($sformatf("vec%0d.pc", i),  if_id_pc, vec[i].epc);
                chk($sformatf("vec%0d.pc4", i), if_id_pc_plus4, vec[i].epc + 32'd4);
            end
        end

        // Top-of-IMEM boundary from a clean fault flag.
        do_reset();
        step(0, 0, 1, 32'h7FC);
        chk("top.redir_valid", {31'b0, if_id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("top.7fc_valid", {31'b0, if_id_valid}, 32'h1);
        chk("top.7fc_instr", if_id_instruction, rom[510]);
        chk("top.7fc_pc", if_id_pc, 32'h7FC);
        step(0, 0, 0, 0);
        chk("top.800_valid", {31'b0, if_id_valid}, 32'h1);
        chk("top.800_instr", if_id_instruction, rom[511]);
        chk("top.800_pc4", if_id_pc_plus4, 32'h804);
        chk("top.800_fault", {31'b0, fetch_fault}, 32'h0);
        step(0, 0, 0, 0);
        chk("top.804_valid", {31'b0, if_id_valid}, 32'h0);
        chk("top.804_instr", if_id_instruction, 32'h0);
        chk("top.804_fault", {31'b0, fetch_fault}, 32'h1);
        chk("top.804_count", fetch_count, 32'h2);

        // PC wrap past 0xFFFF_FFFC.
        do_reset();
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap.addr", imem_address, 32'h0);
        chk("wrap.fffc_valid", {31'b0, if_id_valid}, 32'h0);
        chk("wrap.fffc_fault", {31'b0, fetch_fault}, 32'h1);
        step(0, 0, 0, 0);
        chk("wrap.zero_valid", {31'b0, if_id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("wrap.four_valid", {31'b0, if_id_valid}, 32'h1);
        chk("wrap.four_instr", if_id_instruction, rom[0]);

        // Reset dropped mid-cycle while stall and redirect are active.
        step(0, 0, 0, 0);
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
        #2 reset = 1'b0;
        #1 chk_reset("mid_rst");
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic against the model, with periodic async resets.
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            logic st, fl, rv;
            logic [31:0] tg;
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10);
            rv = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 4))
                0: tg = {$urandom_range(0, 32'h240), 2'b00};
                1: tg = 32'h7F8;
                2: tg = {$urandom_range(1, 8), 2'b00};
                3: tg = $urandom_range(0, 32'h900);
                default: tg = 32'hFFFF_FFF8;
            endcase
            step(st, fl, rv, tg);
            model_edge(st, fl, rv, tg);
            cmp_model();
            if (i % 500 == 250) begin
                do_reset();
                model_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of IMEM: owns the program counter, drives the IMEM address, and registers the returned instruction into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects from EX, and flushes.
- Flags misaligned and out-of-range fetches.
- IMEM is combinational: word index = (address-4)>>2, valid addresses 4..SIZE, so the first ROM word sits at address 4.

Parameters:
- RESET_PC, 32'h0000_0004, PC value after reset; fetches IMEM word 0.
- IMEM_SIZE, 32'h0000_0800, IMEM byte size; highest legal fetch address = IMEM_SIZE.
- NOP_WORD, 32'h0000_0000, instruction injected on bubble or fault.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and IF/ID contents.
- flush  input  1  invalidate IF/ID on next edge.
- redirect_valid  input  1  branch taken or jump resolved.
- redirect_target  input  32  new fetch address.
- imem_address  output  32  combinational, equals pc.
- imem_instruction  input  32  IMEM data, same cycle as imem_address.
- if_id_instruction  output  32  registered instruction.
- if_id_pc  output  32  registered fetch address of that instruction.
- if_id_pc_plus4  output  32  registered if_id_pc+4.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  sticky: misaligned or out-of-range fetch seen.
- fetch_count  output  32  count of instructions delivered (if_id_valid rising-edge loads).

Behaviour:
- Reset (reset=0, asynchronous) sets: pc=RESET_PC, if_id_instruction=NOP_WORD, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, fetch_fault=0, fetch_count=0. After release, the first edge loads ROM word 0.
- Fetch legality: fetch is legal iff pc[1:0]==0 and 4<=pc<=IMEM_SIZE. Otherwise IF/ID loads NOP_WORD with valid=0 and fetch_fault sets; it clears only on reset.
- Next-PC priority per edge:
  1. redirect_valid: pc<=redirect_target. IF/ID loads a bubble (valid=0, NOP_WORD) because the wrong-path word is discarded. Overrides stall and flush.
  2. stall: pc and all IF/ID registers hold. fetch_count holds.
  3. flush: pc<=pc+4. IF/ID loads a bubble.
  4. Normal: pc<=pc+4. IF/ID loads imem_instruction, pc, and pc+4, with valid equal to fetch legality.
- Latency: an instruction appears at if_id_* one edge after its address is driven. The redirect penalty is exactly one bubble.
- Redirect target is not masked. A misaligned target is fetched on the following cycle and faults there.
- PC arithmetic is 32-bit modulo. Wrap from 32'hFFFF_FFFC to 0 is allowed, and the resulting fetch is out-of-range (faults).
- fetch_count increments by 1 on each edge that loads if_id_valid=1. It wraps modulo 2^32.
- Reset asserted mid-stall or mid-redirect aborts everything. No state survives.

Decomposition:
- Shared package/include `mips_defs`: NOP_WORD, RESET_PC, IMEM_SIZE, and PC_INCR=4.
- One natural sub-module, `if_id_reg`: the IF/ID pipeline register with hold/bubble controls, reused by later stage registers.
- PC logic and the legality check stay in the top module.

Test Plan:
- Reset then 4 free-running cycles, with IMEM words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x00000000 -> IF/ID shows these in order with if_id_pc=4,8,12,16, valid=1, and fetch_count=4.
- stall held 3 cycles at pc=12 -> pc stays 12, IF/ID stays unchanged, fetch_count unchanged; on release, the next edge loads the pc=12 word.
- redirect_valid with target 0x40 while stall=1 -> pc=0x40 next edge and if_id_valid=0. One edge later if_id_pc=0x40 with valid=1.
- flush alone at pc=8 -> if_id_valid=0 and if_id_instruction=0; pc advances to 12.
- redirect to 0x42 -> the following fetch gives valid=0 and fetch_fault=1. fetch_fault stays 1 after a later redirect to 0x10.
- Sequential fetch to pc=IMEM_SIZE (0x800) -> valid load. Next pc=0x804 -> valid=0, fault=1. Asynchronous reset mid-cycle -> all outputs return to reset values immediately.
